// File: rtl/timer_mtime_pkg.sv
// Shared configuration for the machine timer: RTC divider, timer window,
// register offsets, reset value of mtimecmp and the byte-lane merge helper.
package timer_mtime_pkg;

  localparam int unsigned clk_divider_rtc = 1524;

  localparam logic [31:0] timer_base = 32'h0020_0000;
  localparam logic [31:0] timer_top  = 32'h0020_000F;

  localparam logic [3:0] mtime_lo    = 4'h0;
  localparam logic [3:0] mtime_hi    = 4'h4;
  localparam logic [3:0] mtimecmp_lo = 4'h8;
  localparam logic [3:0] mtimecmp_hi = 4'hC;

  localparam logic [63:0] timer_cmp_reset = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic {
    BUS_IDLE,
    BUS_RESP
  } bus_state_e;

  // Replace the strobed byte lanes of oldWord with the matching lanes of wdata.
  function automatic logic [31:0] merge_bytes(input logic [31:0] oldWord,
                                              input logic [31:0] wdata,
                                              input logic [3:0]  wstrb);
    logic [31:0] result;
    result = oldWord;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) result[8*i +: 8] = wdata[8*i +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// RTC prescaler: counts 0..2*DIVIDER+1 and pulses tick_o on the last count,
// giving one mtime tick every 2*(DIVIDER+1) clocks.
module timer_prescaler
  import timer_mtime_pkg::*;
#(
  parameter int unsigned DIVIDER = clk_divider_rtc
) (
  input  logic clock,
  input  logic reset,
  output logic tick_o
);

  localparam logic [31:0] CountTop = 32'(2 * DIVIDER + 1);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  assign tick_o = (cnt_q == CountTop);

  always_comb begin
    cnt_d = tick_o ? 32'd0 : cnt_q + 32'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_q <= 32'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer_mtime.sv
// Machine timer peripheral: 64-bit mtime/mtimecmp behind a valid/ready
// data-memory handshake, with a registered machine timer interrupt.
module timer_mtime
  import timer_mtime_pkg::*;
#(
  parameter int unsigned DIVIDER   = clk_divider_rtc,
  parameter logic [63:0] CMP_RESET = timer_cmp_reset
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        timer_valid,
  input  logic        timer_instr,
  input  logic [31:0] timer_addr,
  input  logic [31:0] timer_wdata,
  input  logic [3:0]  timer_wstrb,
  output logic [31:0] timer_rdata,
  output logic        timer_ready,
  output logic        timer_irpt
);

  bus_state_e  state_q, state_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        irpt_q, irpt_d;

  logic        tick;
  logic        accept;
  logic        doWrite;
  logic [3:0]  regOffset;
  logic [31:0] readWord;
  logic [63:0] mtimeInc;
  logic        unusedAddr;

  assign unusedAddr = ^{timer_addr[31:4], timer_addr[1:0]};

  timer_prescaler #(
    .DIVIDER(DIVIDER)
  ) uPrescaler (
    .clock (clock),
    .reset (reset),
    .tick_o(tick)
  );

  assign regOffset   = {timer_addr[3:2], 2'b00};
  assign timer_ready = (state_q == BUS_RESP);
  assign timer_rdata = rdata_q;
  assign timer_irpt  = irpt_q;

  // A request is taken only from idle, so the response cycle masks valid.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      BUS_IDLE: begin
        if (timer_valid) begin
          accept  = 1'b1;
          state_d = BUS_RESP;
        end
      end
      BUS_RESP: state_d = BUS_IDLE;
      default:  state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    readWord = 32'd0;
    case (regOffset)
      mtime_lo:    readWord = mtime_q[31:0];
      mtime_hi:    readWord = mtime_q[63:32];
      mtimecmp_lo: readWord = mtimecmp_q[31:0];
      mtimecmp_hi: readWord = mtimecmp_q[63:32];
      default:     readWord = 32'd0;
    endcase
  end

  // Writes land on top of the already-incremented mtime so a coincident tick
  // still reaches the bytes software did not strobe.
  always_comb begin
    doWrite    = accept && !timer_instr;
    mtimeInc   = mtime_q + 64'(tick);
    mtime_d    = mtimeInc;
    mtimecmp_d = mtimecmp_q;
    if (doWrite) begin
      case (regOffset)
        mtime_lo:    mtime_d[31:0]     = merge_bytes(mtimeInc[31:0], timer_wdata, timer_wstrb);
        mtime_hi:    mtime_d[63:32]    = merge_bytes(mtimeInc[63:32], timer_wdata, timer_wstrb);
        mtimecmp_lo: mtimecmp_d[31:0]  = merge_bytes(mtimecmp_q[31:0], timer_wdata, timer_wstrb);
        mtimecmp_hi: mtimecmp_d[63:32] = merge_bytes(mtimecmp_q[63:32], timer_wdata, timer_wstrb);
        default:     mtimecmp_d        = mtimecmp_q;
      endcase
    end
    rdata_d = rdata_q;
    if (accept) rdata_d = timer_instr ? 32'd0 : readWord;
    irpt_d = (mtime_d >= mtimecmp_d);
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= BUS_IDLE;
      mtime_q    <= 64'd0;
      mtimecmp_q <= CMP_RESET;
      rdata_q    <= 32'd0;
      irpt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      rdata_q    <= rdata_d;
      irpt_q     <= irpt_d;
    end
  end

endmodule

// File: tb/tb_timer_mtime.sv
// Self-checking bench for timer_mtime: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a model.
module tb_timer_mtime;

  localparam int D = 1;
  localparam logic [31:0] Base = 32'h0020_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        timer_valid = 1'b0;
  logic        timer_instr = 1'b0;
  logic [31:0] timer_addr = Base;
  logic [31:0] timer_wdata = 32'd0;
  logic [3:0]  timer_wstrb = 4'd0;
  logic [31:0] timer_rdata;
  logic        timer_ready;
  logic        timer_irpt;

  int checks = 0;
  int errors = 0;
  int edgeCount = 0;
  bit checkEn = 1'b0;

  logic [63:0] mTime;
  logic [63:0] mCmp;
  int          mCnt;
  logic        mReady;
  logic [31:0] mRdata;
  logic        mIrpt;

  timer_mtime #(
    .DIVIDER  (D),
    .CMP_RESET(64'hFFFF_FFFF_FFFF_FFFF)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .timer_valid(timer_valid),
    .timer_instr(timer_instr),
    .timer_addr (timer_addr),
    .timer_wdata(timer_wdata),
    .timer_wstrb(timer_wstrb),
    .timer_rdata(timer_rdata),
    .timer_ready(timer_ready),
    .timer_irpt (timer_irpt)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mtime counts ticks, one tick per 2*(D+1) clocks; a
  // request is answered one cycle later from the pre-edge register values.
  always @(posedge clock) begin : model
    logic [63:0] nt;
    logic [63:0] nc;
    logic [63:0] word64;
    logic        tk;
    int          pos;
    edgeCount++;
    if (!reset) begin
      mTime  = 64'd0;
      mCmp   = 64'hFFFF_FFFF_FFFF_FFFF;
      mCnt   = 0;
      mReady = 1'b0;
      mRdata = 32'd0;
      mIrpt  = 1'b0;
    end else begin
      tk = (mCnt == 2 * D + 1);
      nt = mTime + {63'd0, tk};
      nc = mCmp;
      if (timer_valid && !mReady) begin
        word64 = timer_addr[3] ? mCmp : mTime;
        if (timer_addr[2]) word64 = word64 >> 32;
        mRdata = timer_instr ? 32'd0 : word64[31:0];
        if (!timer_instr) begin
          for (int i = 0; i < 4; i++) begin
            if (timer_wstrb[i]) begin
              pos = (timer_addr[2] ? 32 : 0) + 8 * i;
              if (timer_addr[3]) nc[pos +: 8] = timer_wdata[8*i +: 8];
              else               nt[pos +: 8] = timer_wdata[8*i +: 8];
            end
          end
        end
        mReady = 1'b1;
      end else begin
        mReady = 1'b0;
      end
      mCnt  = tk ? 0 : mCnt + 1;
      mTime = nt;
      mCmp  = nc;
      mIrpt = (nt >= nc);
    end
  end

  // Outputs are compared against the model on every falling edge.
  always @(negedge clock) begin
    if (checkEn) begin
      checkOutput("model_ready", 64'(timer_ready), 64'(mReady));
      checkOutput("model_rdata", 64'(timer_rdata), 64'(mRdata));
      checkOutput("model_irpt",  64'(timer_irpt),  64'(mIrpt));
    end
  end

  // One request: valid for one cycle, response sampled just after the next edge.
  task automatic applyStimulus(input logic [3:0] offset, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input logic instr,
                               output logic [31:0] rdata);
    @(posedge clock);
    #2;
    timer_valid = 1'b1;
    timer_addr  = Base | {28'd0, offset};
    timer_wdata = wdata;
    timer_wstrb = wstrb;
    timer_instr = instr;
    @(posedge clock);
    #2;
    timer_valid = 1'b0;
    timer_wstrb = 4'd0;
    timer_instr = 1'b0;
    checkOutput("ready_latency", 64'(timer_ready), 64'd1);
    rdata = timer_rdata;
  endtask

  // Leaves the bench two ns after the last reset edge.
  task automatic doReset();
    @(posedge clock);
    #2;
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b1;
  endtask

  initial begin
    logic [31:0] rd;
    int relEdge;

    doReset();
    checkEn = 1'b1;
    checkOutput("reset_ready", 64'(timer_ready), 64'd0);
    checkOutput("reset_rdata", 64'(timer_rdata), 64'd0);
    checkOutput("reset_irpt",  64'(timer_irpt),  64'd0);

    repeat (39) @(posedge clock);
    applyStimulus(4'h0, 32'd0, 4'h0, 1'b0, rd);
    checkOutput("idle40_mtime_lo", 64'(rd), 64'd10);
    checkOutput("idle40_irpt", 64'(timer_irpt), 64'd0);

    doReset();
    relEdge = edgeCount;
    applyStimulus(4'h8, 32'd5, 4'hF, 1'b0, rd);
    applyStimulus(4'hC, 32'd0, 4'hF, 1'b0, rd);
    for (int n = 0; n < 100 && !timer_irpt; n++) begin
      @(posedge clock);
      #2;
    end
    checkOutput("irpt_rise_edge", 64'(edgeCount - relEdge), 64'd20);
    applyStimulus(4'hC, 32'd1, 4'hF, 1'b0, rd);
    checkOutput("irpt_clear_on_cmp_raise", 64'(timer_irpt), 64'd0);

    doReset();
    applyStimulus(4'h0, 32'hFFFF_FFFF, 4'hF, 1'b0, rd);
    @(posedge clock);
    applyStimulus(4'h4, 32'd0, 4'h0, 1'b0, rd);
    checkOutput("carry_mtime_hi", 64'(rd), 64'd1);
    applyStimulus(4'h0, 32'd0, 4'h0, 1'b0, rd);
    checkOutput("carry_mtime_lo", 64'(rd), 64'd0);

    doReset();
    repeat (2) @(posedge clock);
    applyStimulus(4'h0, 32'hFFFF_FFF0, 4'hF, 1'b0, rd);
    applyStimulus(4'h4, 32'd0, 4'h0, 1'b0, rd);
    checkOutput("tickwrite_mtime_hi", 64'(rd), 64'd0);
    applyStimulus(4'h0, 32'd0, 4'h0, 1'b0, rd);
    checkOutput("tickwrite_mtime_lo", 64'(rd), 64'hFFFF_FFF0);

    doReset();
    applyStimulus(4'h8, 32'h0000_AB00, 4'b0010, 1'b0, rd);
    applyStimulus(4'h8, 32'd0, 4'h0, 1'b0, rd);
    checkOutput("partial_strobe", 64'(rd), 64'hFFFF_ABFF);
    applyStimulus(4'h8, 32'd0, 4'hF, 1'b1, rd);
    checkOutput("instr_rdata", 64'(rd), 64'd0);
    applyStimulus(4'h8, 32'd0, 4'h0, 1'b0, rd);
    checkOutput("instr_no_write", 64'(rd), 64'hFFFF_ABFF);

    applyStimulus(4'hC, 32'd0, 4'hF, 1'b0, rd);
    applyStimulus(4'h8, 32'd0, 4'hF, 1'b0, rd);
    checkOutput("irpt_cmp_zero", 64'(timer_irpt), 64'd1);
    @(posedge clock);
    #2;
    timer_valid = 1'b1;
    timer_addr  = Base | 32'h8;
    timer_wdata = 32'h1234;
    timer_wstrb = 4'hF;
    reset       = 1'b0;
    @(posedge clock);
    #2;
    checkOutput("reset_drop_ready", 64'(timer_ready), 64'd0);
    reset       = 1'b1;
    timer_valid = 1'b0;
    timer_wstrb = 4'h0;
    @(posedge clock);
    #2;
    checkOutput("reset_drop_ready_after", 64'(timer_ready), 64'd0);
    checkOutput("reset_drop_irpt", 64'(timer_irpt), 64'd0);
    applyStimulus(4'h8, 32'd0, 4'h0, 1'b0, rd);
    checkOutput("reset_cmp_lo", 64'(rd), 64'hFFFF_FFFF);
    applyStimulus(4'hC, 32'd0, 4'h0, 1'b0, rd);
    checkOutput("reset_cmp_hi", 64'(rd), 64'hFFFF_FFFF);

    // Random traffic, including held valid, instruction fetches and resets.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock);
      #2;
      reset       = ($urandom_range(299) != 0);
      timer_valid = ($urandom_range(2) != 0);
      timer_instr = ($urandom_range(7) == 0);
      timer_addr  = Base | {28'd0, 2'($urandom), 2'($urandom)};
      timer_wstrb = ($urandom_range(1) == 0) ? 4'h0 : 4'($urandom);
      if (timer_addr[3] && $urandom_range(1) == 0)
        timer_wdata = 32'($urandom_range(60));
      else if ($urandom_range(3) == 0)
        timer_wdata = 32'hFFFF_FFFF - 32'($urandom_range(3));
      else
        timer_wdata = $urandom;
    end
    @(posedge clock);
    #2;
    reset       = 1'b1;
    timer_valid = 1'b0;
    timer_instr = 1'b0;
    timer_wstrb = 4'h0;
    repeat (8) @(posedge clock);
    #2;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
